// File: rtl/bitcount_result_log.sv
// ---------------------------------------------------------------------------
// bitcount_result_log
//
// Capture stage that sits behind the 8-bit ones-counter. It owns the start
// handshake to the counter, logs every finished 4-bit result into a small
// circular history with a saturating running total, and drives the DE1_SoC
// seven-segment displays for the newest result and the total.
//
// Parameters
//   DEPTH      history entries (power of two)
//   TOT_W      running-total width (saturates at all ones); must be >= 8
//              because the two total digits show total[7:0]
//
// Ports
//   CLOCK_50   in   sole clock, rising edge
//   reset      in   asynchronous, active-low
//   start_req  in   raw run request from SW[9], asynchronous to CLOCK_50
//   clr        in   clear history/total/run count (only honoured in IDLE)
//   done       in   counter is in its done state
//   result     in   counter result, valid while done = 1
//   sel        in   history read index, 0 = newest
//   start      out  to counter s input
//   busy       out  high in RUN or WAIT_LOW
//   hist_out   out  history entry at sel (0 when sel >= valid_cnt)
//   valid_cnt  out  number of valid history entries, 0..DEPTH
//   total      out  saturating sum of captured results
//   run_count  out  completed captures, wraps 15 -> 0
//   hex_last   out  active-low segments, newest result
//   hex_tot_lo out  active-low segments, total[3:0]
//   hex_tot_hi out  active-low segments, total[7:4]
// ---------------------------------------------------------------------------
module bitcount_result_log #(
  parameter int DEPTH = 4,
  parameter int TOT_W = 8
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       start_req,
  input  logic                       clr,
  input  logic                       done,
  input  logic [3:0]                 result,
  input  logic [$clog2(DEPTH)-1:0]   sel,
  output logic                       start,
  output logic                       busy,
  output logic [3:0]                 hist_out,
  output logic [$clog2(DEPTH):0]     valid_cnt,
  output logic [TOT_W-1:0]           total,
  output logic [3:0]                 run_count,
  output logic [6:0]                 hex_last,
  output logic [6:0]                 hex_tot_lo,
  output logic [6:0]                 hex_tot_hi
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Seven-segment decode, DE1 active-low ordering {g,f,e,d,c,b,a}
  // -------------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    unique case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;  // F
    endcase
    return seg;
  endfunction

  // -------------------------------------------------------------------------
  // Request synchronizer: q1/q2 resolve metastability, q3 remembers the
  // previous synchronized level so a rising edge lasts exactly one cycle.
  // -------------------------------------------------------------------------
  logic q1, q2, q3;
  logic req_rise;
  logic req_lvl;

  // NOTE: clocked state is always written with non-blocking assignments so
  // every flop samples the values from before the edge; blocking here would
  // collapse q1..q3 into a single stage.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
      q3 <= 1'b0;
    end else begin
      q1 <= start_req;
      q2 <= q1;
      q3 <= q2;
    end
  end

  assign req_rise = q2 & ~q3;
  assign req_lvl  = q2;

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  state_t state, state_nxt;
  logic   capture;
  logic   clear;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    busy      = 1'b0;
    capture   = 1'b0;
    clear     = 1'b0;
    unique case (state)
      IDLE: begin
        // A clear in the same cycle as a request edge swallows the edge.
        if (clr) begin
          clear = 1'b1;
        end else if (req_rise) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        start = 1'b1;
        busy  = 1'b1;
        // done wins over an abort seen in the same cycle.
        if (done) begin
          capture   = 1'b1;
          state_nxt = WAIT_LOW;
        end else if (!req_lvl) begin
          state_nxt = IDLE;
        end
      end
      WAIT_LOW: begin
        busy = 1'b1;
        if (!done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // History buffer, counters and saturating total
  // -------------------------------------------------------------------------
  logic [3:0]       hist [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [TOT_W:0]   sum_ext;
  logic [TOT_W-1:0] total_nxt;

  // One extra bit catches the carry out so overflow clamps instead of wrapping.
  assign sum_ext   = {1'b0, total} + (TOT_W + 1)'(result);
  assign total_nxt = sum_ext[TOT_W] ? {TOT_W{1'b1}} : sum_ext[TOT_W-1:0];

  // NOTE: the history array is reset along with the counters because the
  // displays and readout must show zeros straight out of reset; this keeps
  // it in flops rather than a RAM macro, which is fine at this depth.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist[i] <= 4'd0;
      end
      wr_ptr    <= '0;
      valid_cnt <= '0;
      total     <= '0;
      run_count <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist[i] <= 4'd0;
      end
      wr_ptr    <= '0;
      valid_cnt <= '0;
      total     <= '0;
      run_count <= '0;
    end else if (capture) begin
      hist[wr_ptr] <= result;
      wr_ptr       <= wr_ptr + PTR_W'(1);
      if (valid_cnt != CNT_W'(DEPTH)) begin
        valid_cnt <= valid_cnt + CNT_W'(1);
      end
      total        <= total_nxt;
      run_count    <= run_count + 4'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Readout: wr_ptr points at the next free slot, so the newest entry is one
  // behind it and sel walks further back in time. The subtraction wraps
  // naturally because DEPTH is a power of two.
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0] rd_idx;
  logic [PTR_W-1:0] newest_idx;
  logic [3:0]       newest;

  assign rd_idx     = wr_ptr - PTR_W'(1) - sel;
  assign newest_idx = wr_ptr - PTR_W'(1);

  assign hist_out = ({1'b0, sel} < valid_cnt) ? hist[rd_idx] : 4'd0;
  assign newest   = (valid_cnt != '0) ? hist[newest_idx] : 4'd0;

  // -------------------------------------------------------------------------
  // Displays
  // -------------------------------------------------------------------------
  assign hex_last   = seg7(newest);
  assign hex_tot_lo = seg7(total[3:0]);
  assign hex_tot_hi = seg7(total[7:4]);

endmodule

// File: tb/tb_bitcount_result_log.sv
// ---------------------------------------------------------------------------
// tb_bitcount_result_log
//
// Directed bench for bitcount_result_log: a table of single runs with
// hand-computed totals/counts/displays, plus hand-written sequences for
// start latency, abort, ignored edges, clear priority, saturation and an
// asynchronous reset in the middle of a run.
// ---------------------------------------------------------------------------
module tb_bitcount_result_log;

  logic       clk;
  logic       rst_n;
  logic       start_req;
  logic       clr;
  logic       done;
  logic [3:0] result;
  logic [1:0] sel;
  logic       start;
  logic       busy;
  logic [3:0] hist_out;
  logic [2:0] valid_cnt;
  logic [7:0] total;
  logic [3:0] run_count;
  logic [6:0] hex_last;
  logic [6:0] hex_tot_lo;
  logic [6:0] hex_tot_hi;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_F = 7'b0001110;

  bitcount_result_log #(.DEPTH(4), .TOT_W(8)) dut (
    .CLOCK_50   (clk),
    .reset      (rst_n),
    .start_req  (start_req),
    .clr        (clr),
    .done       (done),
    .result     (result),
    .sel        (sel),
    .start      (start),
    .busy       (busy),
    .hist_out   (hist_out),
    .valid_cnt  (valid_cnt),
    .total      (total),
    .run_count  (run_count),
    .hex_last   (hex_last),
    .hex_tot_lo (hex_tot_lo),
    .hex_tot_hi (hex_tot_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the counter handshake to go high.
  task automatic wait_start();
    for (int i = 0; i < 20; i++) begin
      if (start) break;
      tick();
    end
    check("start_wait", start, 1);
  endtask

  // Full handshake: request, one-cycle done with the given result, then
  // drop everything long enough for the synchronizer to see a low level.
  task automatic do_run(input logic [3:0] res);
    start_req = 1'b1;
    wait_start();
    done   = 1'b1;
    result = res;
    tick();
    done      = 1'b0;
    start_req = 1'b0;
    repeat (3) tick();
  endtask

  typedef struct {
    logic [3:0] res;
    int         exp_total;
    int         exp_valid;
    int         exp_rc;
    logic [6:0] exp_hex;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{res: 4'd1, exp_total: 1,  exp_valid: 1, exp_rc: 1, exp_hex: SEG_1};
    vecs[1] = '{res: 4'd2, exp_total: 3,  exp_valid: 2, exp_rc: 2, exp_hex: SEG_2};
    vecs[2] = '{res: 4'd3, exp_total: 6,  exp_valid: 3, exp_rc: 3, exp_hex: 7'b0110000};
    vecs[3] = '{res: 4'd4, exp_total: 10, exp_valid: 4, exp_rc: 4, exp_hex: 7'b0011001};
    vecs[4] = '{res: 4'd8, exp_total: 18, exp_valid: 4, exp_rc: 5, exp_hex: SEG_8};

    rst_n     = 1'b0;
    start_req = 1'b0;
    clr       = 1'b0;
    done      = 1'b0;
    result    = 4'd0;
    sel       = 2'd0;

    // ---------------- reset then idle ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    check("idle_start", start, 0);
    check("idle_total", total, 0);
    check("idle_valid", valid_cnt, 0);
    check("idle_rc", run_count, 0);
    check("idle_hist", hist_out, 0);
    check("idle_hex_last", hex_last, SEG_0);
    check("idle_hex_lo", hex_tot_lo, SEG_0);
    check("idle_hex_hi", hex_tot_hi, SEG_0);

    // ---------------- single run with exact latency ----------------
    start_req = 1'b1;
    tick();                         // q1
    tick();                         // q2
    check("lat_k1_start", start, 0);
    tick();                         // RUN
    check("lat_k2_start", start, 1);
    check("lat_k2_busy", busy, 1);
    done   = 1'b1;
    result = 4'd5;
    tick();
    check("cap_start", start, 0);
    check("cap_busy", busy, 1);
    check("cap_hist", hist_out, 5);
    check("cap_total", total, 5);
    check("cap_rc", run_count, 1);
    check("cap_valid", valid_cnt, 1);
    check("cap_hex_last", hex_last, SEG_5);
    sel = 2'd1;
    #1;
    check("cap_sel_beyond_valid", hist_out, 0);
    sel       = 2'd0;
    done      = 1'b0;
    start_req = 1'b0;
    tick();
    check("cap_back_idle", busy, 0);
    repeat (2) tick();

    // ---------------- clear then table of runs ----------------
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_total", total, 0);
    check("clr_rc", run_count, 0);
    check("clr_valid", valid_cnt, 0);

    for (int i = 0; i < 5; i++) begin
      do_run(vecs[i].res);
      check($sformatf("vec%0d_total", i), total, vecs[i].exp_total);
      check($sformatf("vec%0d_valid", i), valid_cnt, vecs[i].exp_valid);
      check($sformatf("vec%0d_rc", i), run_count, vecs[i].exp_rc);
      check($sformatf("vec%0d_hex_last", i), hex_last, vecs[i].exp_hex);
    end

    begin
      logic [3:0] exp_hist [4];
      exp_hist[0] = 4'd8;
      exp_hist[1] = 4'd4;
      exp_hist[2] = 4'd3;
      exp_hist[3] = 4'd2;
      for (int s = 0; s < 4; s++) begin
        sel = 2'(s);
        #1;
        check($sformatf("wrap_sel%0d", s), hist_out, exp_hist[s]);
      end
      sel = 2'd0;
    end
    check("wrap_hex_hi", hex_tot_hi, SEG_1);
    check("wrap_hex_lo", hex_tot_lo, SEG_2);

    // ---------------- abort before done ----------------
    start_req = 1'b1;
    wait_start();
    start_req = 1'b0;
    tick();
    tick();
    check("abort_still_run", busy, 1);
    tick();
    check("abort_idle", busy, 0);
    check("abort_rc", run_count, 5);
    check("abort_total", total, 18);
    tick();

    // ---------------- edges in WAIT_LOW ignored, clr ignored ----------------
    start_req = 1'b1;
    wait_start();
    done   = 1'b1;
    result = 4'd1;
    tick();
    check("wl_rc", run_count, 6);
    check("wl_total", total, 19);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("wl_clr_ignored", total, 19);
    start_req = 1'b0;
    repeat (3) tick();
    start_req = 1'b1;
    repeat (4) tick();
    check("wl_busy", busy, 1);
    check("wl_no_start", start, 0);
    check("wl_rc_once", run_count, 6);
    done = 1'b0;
    tick();
    check("wl_to_idle", busy, 0);
    repeat (4) tick();
    check("wl_not_queued", busy, 0);
    check("wl_rc_final", run_count, 6);

    // ---------------- clr beats a request edge in IDLE ----------------
    start_req = 1'b0;
    repeat (3) tick();
    clr       = 1'b1;
    start_req = 1'b1;
    repeat (4) tick();
    clr = 1'b0;
    check("clrp_total", total, 0);
    check("clrp_valid", valid_cnt, 0);
    check("clrp_rc", run_count, 0);
    check("clrp_idle", busy, 0);
    repeat (3) tick();
    check("clrp_stays_idle", busy, 0);
    start_req = 1'b0;
    repeat (3) tick();

    // ---------------- saturation ----------------
    for (int i = 1; i <= 32; i++) begin
      do_run(4'd8);
      if (i == 16) begin
        check("sat16_total", total, 128);
        check("sat16_rc", run_count, 0);
      end
      if (i == 31) begin
        check("sat31_total", total, 248);
      end
    end
    check("sat_total", total, 255);
    check("sat_rc", run_count, 0);
    check("sat_valid", valid_cnt, 4);
    check("sat_hex_hi", hex_tot_hi, SEG_F);
    check("sat_hex_lo", hex_tot_lo, SEG_F);
    sel = 2'd3;
    #1;
    check("sat_oldest", hist_out, 8);
    sel = 2'd0;

    // ---------------- async reset mid-run ----------------
    start_req = 1'b1;
    wait_start();
    #2;
    rst_n = 1'b0;
    #1;
    check("amid_start", start, 0);
    check("amid_busy", busy, 0);
    check("amid_total", total, 0);
    check("amid_rc", run_count, 0);
    check("amid_valid", valid_cnt, 0);
    check("amid_hex_last", hex_last, SEG_0);
    start_req = 1'b0;
    done      = 1'b1;
    result    = 4'd7;
    repeat (2) tick();
    rst_n = 1'b1;
    done  = 1'b0;
    repeat (3) tick();
    check("post_rst_idle", busy, 0);
    check("post_rst_no_cap", run_count, 0);
    check("post_rst_hist", hist_out, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
